// File: rtl/msdap_out_serializer.sv
// MSDAP output stage: paired L/R result FIFO feeding a lock-stepped MSB-first serializer.
// State advances on the falling edge of Sclk; a word starts shifting on the Frame edge after it is armed.
module msdap_out_serializer #(
  parameter int unsigned DATA_W     = 40,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          Sclk,
  input  logic                          Reset_n,
  input  logic                          Frame,
  input  logic                          y_valid,
  input  logic [DATA_W-1:0]             yL,
  input  logic [DATA_W-1:0]             yR,
  output logic                          y_ready,
  output logic                          OutputL,
  output logic                          OutputR,
  output logic                          OutReady,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  state_t            state;
  logic [DATA_W-1:0] sh_l;
  logic [DATA_W-1:0] sh_r;
  logic [CNT_W-1:0]  bit_cnt;

  logic              full_c;
  logic              push_c;
  logic              pop_c;
  logic [LVL_W-1:0]  level_nxt_c;

  // Full is judged on the registered level, so a pop never frees room for a same-cycle push.
  always_comb begin
    full_c      = (fifo_level == LVL_W'(FIFO_DEPTH));
    push_c      = y_valid && !full_c;
    pop_c       = (fifo_level != '0) &&
                  ((state == IDLE) || ((state == SHIFT) && (bit_cnt == '0)));
    level_nxt_c = fifo_level;
    if (push_c && !pop_c) begin
      level_nxt_c = fifo_level + LVL_W'(1);
    end else if (!push_c && pop_c) begin
      level_nxt_c = fifo_level - LVL_W'(1);
    end
  end

  // Pair storage; contents are don't-care until written.
  always_ff @(negedge Sclk) begin
    if (push_c) begin
      mem_l[wr_ptr] <= yL;
      mem_r[wr_ptr] <= yR;
    end
  end

  always_ff @(negedge Sclk) begin
    if (!Reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      y_ready    <= 1'b1;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
      state      <= IDLE;
      sh_l       <= '0;
      sh_r       <= '0;
      bit_cnt    <= '0;
      OutputL    <= 1'b0;
      OutputR    <= 1'b0;
      OutReady   <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        sh_l   <= mem_l[rd_ptr];
        sh_r   <= mem_r[rd_ptr];
      end
      fifo_level <= level_nxt_c;
      y_ready    <= (level_nxt_c != LVL_W'(FIFO_DEPTH));
      if (y_valid && full_c) begin
        overflow <= 1'b1;
      end

      OutputL  <= 1'b0;
      OutputR  <= 1'b0;
      OutReady <= 1'b0;
      case (state)
        IDLE: begin
          if (Frame) begin
            underrun <= 1'b1;
          end
          if (pop_c) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (Frame) begin
            OutputL  <= sh_l[DATA_W-1];
            OutputR  <= sh_r[DATA_W-1];
            OutReady <= 1'b1;
            bit_cnt  <= CNT_W'(DATA_W - 2);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Frame is ignored here; the word always runs to bit 0.
          OutputL  <= sh_l[bit_cnt];
          OutputR  <= sh_r[bit_cnt];
          OutReady <= 1'b1;
          bit_cnt  <= bit_cnt - CNT_W'(1);
          if (bit_cnt == '0) begin
            state <= pop_c ? ARMED : IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msdap_out_serializer.sv
// Bench for msdap_out_serializer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations on levels, flags and emitted words.
module tb_msdap_out_serializer;

  localparam int unsigned DW = 40;
  localparam int unsigned DEPTH = 4;

  logic          Sclk;
  logic          Reset_n;
  logic          Frame;
  logic          y_valid;
  logic [DW-1:0] yL;
  logic [DW-1:0] yR;
  logic          y_ready;
  logic          OutputL;
  logic          OutputR;
  logic          OutReady;
  logic [2:0]    fifo_level;
  logic          overflow;
  logic          underrun;

  msdap_out_serializer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .Sclk(Sclk), .Reset_n(Reset_n), .Frame(Frame), .y_valid(y_valid),
    .yL(yL), .yR(yR), .y_ready(y_ready), .OutputL(OutputL), .OutputR(OutputR),
    .OutReady(OutReady), .fifo_level(fifo_level), .overflow(overflow), .underrun(underrun)
  );

  initial Sclk = 1'b1;
  always #5 Sclk = ~Sclk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // Reference model: FIFO as a queue, one armed pair, one word in flight.
  logic [2*DW-1:0] m_q[$];
  logic [2*DW-1:0] m_aw;
  logic [2*DW-1:0] m_cw;
  bit m_armed, m_shifting, m_take;
  int m_sent, m_sz;
  bit e_l, e_r, e_rdy, e_yr, e_ov, e_un;
  int e_lvl;

  always @(negedge Sclk) begin
    if (!Reset_n) begin
      m_q.delete();
      m_armed = 0; m_shifting = 0; m_sent = 0;
      e_l = 0; e_r = 0; e_rdy = 0; e_ov = 0; e_un = 0;
    end else begin
      m_sz = m_q.size();
      m_take = 0;
      e_l = 0; e_r = 0; e_rdy = 0;
      if (m_shifting) begin
        e_l = m_cw[2*DW-1-m_sent];
        e_r = m_cw[DW-1-m_sent];
        e_rdy = 1;
        m_sent++;
        if (m_sent == DW) begin
          m_shifting = 0;
          m_take = (m_sz > 0);
        end
      end else if (m_armed) begin
        if (Frame) begin
          m_cw = m_aw; m_armed = 0; m_shifting = 1; m_sent = 1;
          e_l = m_cw[2*DW-1]; e_r = m_cw[DW-1]; e_rdy = 1;
        end
      end else begin
        if (Frame) e_un = 1;
        m_take = (m_sz > 0);
      end
      if (y_valid && m_sz == DEPTH) e_ov = 1;
      if (m_take) begin
        m_aw = m_q.pop_front();
        m_armed = 1;
      end
      if (y_valid && m_sz != DEPTH) m_q.push_back({yL, yR});
    end
    e_lvl = m_q.size();
    e_yr = (m_q.size() != DEPTH);
  end

  logic [8:0] act_v, exp_v;
  always @(posedge Sclk) begin
    if (chk_en) begin
      act_v = {OutputL, OutputR, OutReady, y_ready, fifo_level, overflow, underrun};
      exp_v = {e_l, e_r, e_rdy, e_yr, 3'(e_lvl), e_ov, e_un};
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL model_cycle t=%0t {L,R,Rdy,yrdy,lvl,ov,un} got=%b want=%b", $time, act_v, exp_v);
      end
    end
  end

  // Reassemble serial words from the DUT outputs.
  logic [DW-1:0] cl, cr;
  logic [DW-1:0] gl[$];
  logic [DW-1:0] gr[$];
  int cn = 0, run = 0, last_run = 0;
  always @(posedge Sclk) begin
    if (chk_en) begin
      if (OutReady === 1'b1) begin
        cl = {cl[DW-2:0], OutputL};
        cr = {cr[DW-2:0], OutputR};
        cn++; run++;
        if (cn == DW) begin
          gl.push_back(cl); gr.push_back(cr); cn = 0;
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0; cn = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Sclk);
  endtask

  task automatic do_reset();
    Reset_n = 0; y_valid = 0; Frame = 0;
    step(); step();
    chk_en = 1;
    gl.delete(); gr.delete();
    Reset_n = 1;
  endtask

  task automatic frame_word();
    Frame = 1; step(); Frame = 0;
    repeat (41) step();
  endtask

  task automatic chk_word(input string nm, input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic [DW-1:0] al, ar;
    if (gl.size() == 0) begin
      chk({nm, "_present"}, 64'(0), 64'(1));
    end else begin
      al = gl.pop_front(); ar = gr.pop_front();
      chk({nm, "_L"}, 64'(al), 64'(l));
      chk({nm, "_R"}, 64'(ar), 64'(r));
    end
  endtask

  function automatic logic [DW-1:0] mk(input int k);
    return {8'(8'hA0 + k), 32'(32'h1234_5600 + k)};
  endfunction

  logic [DW-1:0] a_l, a_r;
  int lv[7];
  bit ry[7];

  initial begin
    Reset_n = 0; Frame = 0; y_valid = 0; yL = '0; yR = '0;
    a_l = 40'h80_0000_0001;
    a_r = 40'h7F_FFFF_FFFE;

    // Reset state, underrun on empty Frame, then one word end-to-end.
    do_reset();
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_y_ready", 64'(y_ready), 64'(1));
    chk("rst_outready", 64'(OutReady), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_underrun", 64'(underrun), 64'(0));
    Frame = 1; step(); Frame = 0;
    chk("underrun_set", 64'(underrun), 64'(1));
    chk("underrun_outready", 64'(OutReady), 64'(0));
    y_valid = 1; yL = a_l; yR = a_r; step(); y_valid = 0;
    repeat (4) step();
    Frame = 1; step(); Frame = 0;
    chk("first_bit_rdy", 64'(OutReady), 64'(1));
    chk("first_bit_L", 64'(OutputL), 64'(1));
    chk("first_bit_R", 64'(OutputR), 64'(0));
    repeat (45) step();
    chk("w1_count", 64'(gl.size()), 64'(1));
    chk_word("w1", a_l, a_r);
    chk("w1_run_len", 64'(last_run), 64'(40));
    chk("underrun_sticky", 64'(underrun), 64'(1));

    // Fill to overflow with no Frame, then drain in order.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      y_valid = 1; yL = mk(k); yR = ~mk(k);
      step();
      lv[k] = int'(fifo_level); ry[k] = y_ready;
    end
    y_valid = 0;
    chk("fill_lvl1", 64'(lv[1]), 64'(1));
    chk("fill_lvl2_pushpop", 64'(lv[2]), 64'(1));
    chk("fill_lvl3", 64'(lv[3]), 64'(2));
    chk("fill_lvl5", 64'(lv[5]), 64'(4));
    chk("fill_ready5", 64'(ry[5]), 64'(0));
    chk("fill_lvl6", 64'(lv[6]), 64'(4));
    chk("fill_overflow", 64'(overflow), 64'(1));
    repeat (5) frame_word();
    chk("drain_count", 64'(gl.size()), 64'(5));
    for (int k = 1; k <= 5; k++) chk_word("drain", mk(k), ~mk(k));
    chk("drain_empty", 64'(fifo_level), 64'(0));

    // Frame during SHIFT is ignored; next word waits for its own Frame.
    do_reset();
    y_valid = 1; yL = mk(11); yR = ~mk(11); step();
    yL = mk(12); yR = ~mk(12); step();
    y_valid = 0; step();
    Frame = 1; step(); Frame = 0;
    repeat (18) step();
    Frame = 1; step(); Frame = 0;
    chk("mid_frame_rdy", 64'(OutReady), 64'(1));
    repeat (23) step();
    chk("mid_frame_wait_rdy", 64'(OutReady), 64'(0));
    chk("mid_frame_no_underrun", 64'(underrun), 64'(0));
    chk("mid_frame_one_word", 64'(gl.size()), 64'(1));
    frame_word();
    chk_word("mf1", mk(11), ~mk(11));
    chk_word("mf2", mk(12), ~mk(12));

    // Reset mid-word aborts everything.
    do_reset();
    y_valid = 1;
    for (int k = 1; k <= 3; k++) begin
      yL = mk(20 + k); yR = ~mk(20 + k); step();
    end
    y_valid = 0;
    Frame = 1; step(); Frame = 0;
    repeat (28) step();
    chk("abort_pre_lvl", 64'(fifo_level), 64'(2));
    Reset_n = 0; step(); Reset_n = 1;
    chk("abort_rdy", 64'(OutReady), 64'(0));
    chk("abort_L", 64'(OutputL), 64'(0));
    chk("abort_R", 64'(OutputR), 64'(0));
    chk("abort_lvl", 64'(fifo_level), 64'(0));
    chk("abort_y_ready", 64'(y_ready), 64'(1));
    repeat (60) step();
    chk("abort_no_words", 64'(gl.size()), 64'(0));

    // Push+pop at level 2, then push at full coincident with pop.
    do_reset();
    y_valid = 1;
    for (int k = 1; k <= 3; k++) begin
      yL = mk(30 + k); yR = ~mk(30 + k); step();
    end
    y_valid = 0;
    Frame = 1; step(); Frame = 0;
    repeat (38) step();
    chk("pp_pre_lvl", 64'(fifo_level), 64'(2));
    y_valid = 1; yL = mk(34); yR = ~mk(34); step();
    chk("pp_lvl_same", 64'(fifo_level), 64'(2));
    yL = mk(35); yR = ~mk(35); step();
    yL = mk(36); yR = ~mk(36); step();
    y_valid = 0;
    chk("pp_full", 64'(fifo_level), 64'(4));
    Frame = 1; step(); Frame = 0;
    repeat (38) step();
    chk("pp_no_ovf_yet", 64'(overflow), 64'(0));
    y_valid = 1; yL = mk(37); yR = ~mk(37); step(); y_valid = 0;
    chk("pp_full_pop_lvl", 64'(fifo_level), 64'(3));
    chk("pp_full_pop_ovf", 64'(overflow), 64'(1));
    repeat (4) frame_word();
    chk("pp_count", 64'(gl.size()), 64'(6));
    for (int k = 1; k <= 6; k++) chk_word("pp", mk(30 + k), ~mk(30 + k));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
